// File: rtl/ram_arb.sv
// Single-port character RAM arbiter: display (0) wins outright, requesters 1..3 are round-robin, and bursts are capped at MAX_BURST beats.
// Optional macro RAM_ARB_TIMEOUT_EN revokes a grant that has seen no beat for TIMEOUT consecutive cycles.
module ram_arb #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          valid,
  input  logic [3:0]          last,
  input  logic [3:0]          we,
  input  logic [4*ADDR_W-1:0] addr,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [3:0]          gnt,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [3:0]          rvalid,
  output logic                abort
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nx;
  logic [1:0]        owner, owner_nx;
  logic [1:0]        rr_ptr, rr_nx;
  logic [7:0]        beat_cnt, beat_cnt_nx;
  logic [3:0]        gnt_nx;
  logic [3:0]        rvalid_nx;
  logic              abort_nx;
  logic              beat;
  logic              timeout_hit;
  logic              found;
  logic [2:0]        cand;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_chk_burst
    $error("ram_arb: MAX_BURST must be in 2..255");
  end
  if (TIMEOUT < 1) begin : g_chk_tout
    $error("ram_arb: TIMEOUT must be at least 1");
  end

  // gnt is one-hot with owner, so a beat needs only the owner's valid bit
  assign beat      = gnt[owner] & valid[owner];
  assign ram_en    = beat;
  assign ram_we    = beat & we[owner];
  assign ram_addr  = beat ? addr[owner*ADDR_W +: ADDR_W]  : addr_q;
  assign ram_wdata = beat ? wdata[owner*DATA_W +: DATA_W] : wdata_q;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (state != BURST || beat)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = (state == BURST) && !beat && (idle_cnt == IW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_nx       = rr_ptr;
    beat_cnt_nx = beat_cnt;
    gnt_nx      = gnt;
    rvalid_nx   = 4'b0000;
    abort_nx    = 1'b0;
    found       = 1'b0;
    cand        = 3'd0;

    if (beat && !we[owner])
      rvalid_nx[owner] = 1'b1;

    case (state)
      IDLE: begin
        beat_cnt_nx = 8'd0;
        if (req[0]) begin
          state_nx = BURST;
          owner_nx = 2'd0;
          gnt_nx   = 4'b0001;
        end else begin
          for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand > 3'd3)
              cand = cand - 3'd3;
            if (!found && req[cand[1:0]]) begin
              found    = 1'b1;
              state_nx = BURST;
              owner_nx = cand[1:0];
              gnt_nx   = 4'b0001 << cand[1:0];
              rr_nx    = (cand == 3'd3) ? 2'd1 : cand[1:0] + 2'd1;
            end
          end
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_nx = beat_cnt + 8'd1;
          if (last[owner]) begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
          end else if (beat_cnt_nx == 8'(MAX_BURST)) begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
            abort_nx = 1'b1;
          end
        end else if (timeout_hit) begin
          state_nx = IDLE;
          gnt_nx   = 4'b0000;
          abort_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      rr_ptr   <= 2'd1;
      beat_cnt <= 8'd0;
      gnt      <= 4'b0000;
      rvalid   <= 4'b0000;
      abort    <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_nx;
      beat_cnt <= beat_cnt_nx;
      gnt      <= gnt_nx;
      rvalid   <= rvalid_nx;
      abort    <= abort_nx;
    end
  end

  // Address and data hold their last beat value between beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (beat) begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed vector table, hand-written corner sequences, then random traffic against a reference model.
module tb_ram_arb;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int MAXB = 8;
  localparam int TOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0, valid = '0, last = '0, we = '0;
  logic [4*AW-1:0] addr = '0;
  logic [4*DW-1:0] wdata = '0;
  logic [3:0]    gnt, rvalid;
  logic          ram_en, ram_we, abort;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  int errors = 0;
  int checks = 0;

  ram_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .valid(valid), .last(last), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .rvalid(rvalid), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] outs();
    return {gnt, ram_en, ram_we, ram_addr, ram_wdata, rvalid, abort};
  endfunction

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [3:0]  we;
    logic [11:0] a;
    logic [3:0]  gnt;
    logic        en;
    logic        rwe;
    logic [11:0] raddr;
    logic [3:0]  rv;
    logic        ab;
  } vec_t;

  vec_t tbl [0:12];

  // Reference model state
  int         m_own, m_cnt, m_rr, m_idle;
  logic [11:0] m_addr;
  logic [7:0]  m_wd;
  logic [3:0]  m_rv;
  logic        m_ab;

  initial begin
    logic [7:0]  exp_wd;
    logic [3:0]  exp_seq [0:7];
    int          en_cnt, ab_cnt, held, ab_at;
    logic [30:0] exp_o;
    bit          mb;

    tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 12'h000, 4'b0000, 1'b0, 1'b0, 12'h000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 12'h010, 4'b0010, 1'b1, 1'b1, 12'h010, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 12'h011, 4'b0010, 1'b1, 1'b1, 12'h011, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 12'h012, 4'b0010, 1'b1, 1'b1, 12'h012, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 12'h0AA, 4'b0000, 1'b0, 1'b0, 12'h012, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 12'h0AA, 4'b0000, 1'b0, 1'b0, 12'h012, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 12'hED5, 4'b0001, 1'b1, 1'b0, 12'hED5, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 12'h0AA, 4'b0000, 1'b0, 1'b0, 12'hED5, 4'b0001, 1'b0};
    tbl[8]  = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 12'h0AA, 4'b0000, 1'b0, 1'b0, 12'hED5, 4'b0000, 1'b0};
    tbl[9]  = '{4'b1001, 4'b0001, 4'b0001, 4'b0000, 12'h100, 4'b0001, 1'b1, 1'b0, 12'h100, 4'b0000, 1'b0};
    tbl[10] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 12'h0AA, 4'b0000, 1'b0, 1'b0, 12'h100, 4'b0001, 1'b0};
    tbl[11] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 12'h200, 4'b1000, 1'b1, 1'b1, 12'h200, 4'b0000, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 12'h0AA, 4'b0000, 1'b0, 1'b0, 12'h200, 4'b0000, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_outputs", 64'(outs()), 64'd0);

    // Directed table: one row per cycle
    exp_wd = 8'h00;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req = tbl[i].req; valid = tbl[i].valid; last = tbl[i].last; we = tbl[i].we;
      addr = {4{tbl[i].a}};
      wdata = {4{tbl[i].a[7:0] ^ 8'h5A}};
      if (tbl[i].en) exp_wd = tbl[i].a[7:0] ^ 8'h5A;
      #1 chk($sformatf("vec%0d", i), 64'(outs()),
             64'({tbl[i].gnt, tbl[i].en, tbl[i].rwe, tbl[i].raddr, exp_wd, tbl[i].rv, tbl[i].ab}));
    end

    // Round-robin: 1,2,3,1 with an IDLE cycle between grants
    exp_seq[0] = 4'b0000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0000; exp_seq[3] = 4'b0100;
    exp_seq[4] = 4'b0000; exp_seq[5] = 4'b1000; exp_seq[6] = 4'b0000; exp_seq[7] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = 4'b1110; valid = gnt; last = gnt; we = gnt;
      #1 chk($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(exp_seq[i]));
    end
    @(negedge clk);
    req = '0; valid = '0; last = '0; we = '0;

    // MAX_BURST cap: 10 beats without last, req dropped after the grant
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    en_cnt = 0; ab_cnt = 0; ab_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      valid = (i < 10) ? 4'b0010 : 4'b0000; we = 4'b0010; last = 4'b0000;
      addr = {4{12'(12'h300 + i)}};
      #1;
      if (ram_en) begin
        en_cnt++;
        chk($sformatf("burst_addr%0d", i), 64'(ram_addr), 64'(12'h300 + i));
      end
      if (abort) begin
        ab_cnt++;
        ab_at = i;
      end
    end
    chk("burst_beats", 64'(en_cnt), 64'(MAXB));
    chk("burst_abort_count", 64'(ab_cnt), 64'd1);
    chk("burst_abort_cycle", 64'(ab_at), 64'(MAXB));
    valid = '0; we = '0;

    // Grant held without beats
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    held = 0;
    #1;
    while (gnt == 4'b0100 && held < 120) begin
      held++;
      @(negedge clk);
      #1;
    end
`ifdef RAM_ARB_TIMEOUT_EN
    chk("timeout_held", 64'(held), 64'(TOUT));
    chk("timeout_abort", 64'({gnt, abort}), 64'({4'b0000, 1'b1}));
`else
    chk("no_timeout_held", 64'(held), 64'd120);
    valid = 4'b0100; last = 4'b0100;
    @(negedge clk);
    valid = '0; last = '0;
    #1 chk("no_timeout_release", 64'({gnt, abort}), 64'({4'b0000, 1'b0}));
`endif

    // Asynchronous reset mid-burst
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000; valid = 4'b0010; we = 4'b0000;
    #1 chk("pre_rst_en", 64'({gnt, ram_en}), 64'({4'b0010, 1'b1}));
    #1 rst = 1'b1;
    #1 chk("mid_rst", 64'({gnt, ram_en, rvalid}), 64'({4'b0000, 1'b0, 4'b0000}));
    @(negedge clk);
    valid = '0;
    rst = 1'b0;

    // Random traffic against the reference model
    m_own = -1; m_cnt = 0; m_rr = 1; m_idle = 0;
    m_addr = '0; m_wd = '0; m_rv = '0; m_ab = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      req = 4'($urandom);
      for (int b = 0; b < 4; b++) begin
        if (cyc >= 1500 && cyc < 2200)
          valid[b] = ($urandom_range(0, 15) == 0);
        else
          valid[b] = ($urandom_range(0, 3) != 0);
        last[b] = ($urandom_range(0, 7) == 0);
      end
      we = 4'($urandom);
      addr = {4{32'($urandom)}} ^ 48'($urandom);
      wdata = 32'($urandom);
      #1;
      mb = (m_own >= 0) ? valid[m_own] : 1'b0;
      exp_o = {(m_own >= 0) ? 4'(1 << m_own) : 4'b0000,
               mb, mb ? we[m_own] : 1'b0,
               mb ? addr[m_own*AW +: AW] : m_addr,
               mb ? wdata[m_own*DW +: DW] : m_wd,
               m_rv, m_ab};
      chk($sformatf("rand%0d", cyc), 64'(outs()), 64'(exp_o));

      m_rv = (mb && !we[m_own]) ? 4'(1 << m_own) : 4'b0000;
      m_ab = 1'b0;
      if (m_own < 0) begin
        if (req[0]) begin
          m_own = 0;
        end else begin
          for (int k = 0; k < 3; k++) begin
            int c;
            c = ((m_rr - 1 + k) % 3) + 1;
            if (m_own < 0 && req[c]) begin
              m_own = c;
              m_rr = (c % 3) + 1;
            end
          end
        end
        m_cnt = 0; m_idle = 0;
      end else if (mb) begin
        m_addr = addr[m_own*AW +: AW];
        m_wd = wdata[m_own*DW +: DW];
        m_cnt++;
        m_idle = 0;
        if (last[m_own]) begin
          m_own = -1;
        end else if (m_cnt == MAXB) begin
          m_own = -1;
          m_ab = 1'b1;
        end
      end else begin
`ifdef RAM_ARB_TIMEOUT_EN
        m_idle++;
        if (m_idle == TOUT) begin
          m_own = -1;
          m_ab = 1'b1;
        end
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
# ram_arb

Arbiter and sequencer for the single-port character RAM shared by the display read-out, command writer, auto-update engine and overflow resave engine. Each requester requests a burst. The block grants one owner at a time and steers that owner's address, data and write-enable onto the RAM port. Bursts are capped so that no engine can starve the display. The block sits between the mode FSM's engines and the RAM macro, and replaces their ad-hoc direct RAM access.

## Interface
Parameters:
- ADDR_W, 12, RAM address width (covers 3800 character cells)
- DATA_W, 8, RAM data width
- MAX_BURST, 8, maximum beats per grant (2..255)
- TIMEOUT, 16, idle-grant cycles before revocation (used only with the macro below)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  4  burst request; index 0=display, 1=cmd, 2=auto, 3=resave
- valid  in  4  beat valid from requester i
- last  in  4  final beat of requester i's burst
- we  in  4  beat is a write (1) or read (0)
- addr  in  4*ADDR_W  requester i's address at bits [i*ADDR_W +: ADDR_W]
- wdata  in  4*DATA_W  requester i's write data, packed the same way
- gnt  out  4  registered one-hot grant
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- rvalid  out  4  read data on the RAM output is valid for requester i
- abort  out  1  one-cycle pulse: burst ended without the requester's last

## Operation
- FSM states:
  - IDLE: no grant; arbitrate.
  - BURST: exactly one gnt bit high.
- Arbitration in IDLE:
  - req[0] wins unconditionally.
  - Otherwise, round-robin over indices 1..3, starting at rr_ptr.
  - Granting k (1..3) sets rr_ptr to k+1, wrapping 3→1.
  - A display grant leaves rr_ptr unchanged.
- Beat:
  - A beat occurs in any cycle with gnt[i] & valid[i].
  - In that cycle, ram_en=1 and ram_we/ram_addr/ram_wdata come combinationally from requester i.
  - With no beat, ram_en=0, ram_we=0, and addr/wdata hold their last value.
- Inputs from non-granted requesters are ignored, including valid.
- beat_cnt counts beats within a grant and clears on entry to BURST.
- Release to IDLE happens after the cycle in which any of the following occurs:
  - a beat with last[i];
  - the MAX_BURST-th beat;
  - a timeout (macro only).
- abort pulses on release by the MAX_BURST limit without last, and on timeout.
  - A MAX_BURST-th beat that also carries last does not pulse abort.
- Dropping req while granted does not release the grant; only the release rules above end a burst.

## Timing
- Reset values:
  - state=IDLE, gnt=0, rr_ptr=1, beat_cnt=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - rvalid=0, abort=0.
- Reset is asynchronous. Assertion mid-burst drops gnt, ram_en and rvalid immediately; the in-flight beat is lost.
- Grant latency:
  - req sampled in IDLE at edge N; gnt high from cycle N+1.
  - The first beat is possible in cycle N+1.
- Release:
  - gnt falls at the edge after the releasing beat.
  - One IDLE cycle always separates bursts, so the minimum request-to-request turnaround is 2 cycles.
- Read latency: rvalid[i] is asserted exactly one cycle after a read beat of requester i. It is registered and independent of whether gnt is still held.
- abort is registered and high in the first IDLE cycle.
- beat_cnt is 8 bits and never wraps; release occurs at MAX_BURST.

## Configuration
- RAM_ARB_TIMEOUT_EN defined:
  - An idle counter counts consecutive BURST cycles without a beat and clears on each beat.
  - Reaching TIMEOUT releases the grant and pulses abort.
- Undefined: the timeout counter is absent, and a grant with no beats is held indefinitely until last or MAX_BURST.

## Test plan
- Reset, then req[1]=1; 3 write beats to addr 0x010..0x012 with last on the third → gnt=0010 one cycle after req; ram_we=1 with matching addresses; gnt=0 after beat 3; abort=0.
- req[1], req[2] and req[3] held continuously, each bursting 1 beat with last → grant order 1,2,3,1 with one IDLE cycle between grants.
- req[0] and req[3] asserted together in IDLE → display is granted first and rr_ptr is unchanged; resave is granted after the display releases.
- MAX_BURST=8; cmd issues 10 beats without last → release after beat 8; abort pulses once; beats 9–10 do not reach the RAM.
- Display read of addr 0x0ED5 → ram_en=1, ram_we=0 that cycle; rvalid=0001 the next cycle.
- Macro defined, TIMEOUT=16: auto granted and no valid for 16 cycles → gnt drops, abort=1. Macro undefined: gnt still held after 100 cycles. rst asserted mid-burst → gnt=0 and ram_en=0 immediately.
